// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit:
// RV32 opcodes, scoreboard entry layout and the select encoding.
package fwd_hazard_unit_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_CSR       = 7'b1110011;

  // Select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle between the decode stage (master) and the hazard unit (slave).
interface fwd_hazard_unit_if #(
  parameter int DEPTH = 2
) ();
  localparam int SELW = $clog2(DEPTH + 1);

  // id_valid qualifies id_inst; adv is the pipeline-advance strobe and an
  // instruction is accepted into stage 1 only on a cycle with adv=1 and stall=0.
  // While stall=1 decode must hold id_inst; flush drops everything in flight.
  logic [31:0]     id_inst;
  logic            id_valid;
  logic            adv;
  logic            flush;
  logic [SELW-1:0] fwd1_sel;
  logic [SELW-1:0] fwd2_sel;
  logic            stall;

  modport master (
    output id_inst, id_valid, adv, flush,
    input  fwd1_sel, fwd2_sel, stall
  );

  modport slave (
    input  id_inst, id_valid, adv, flush,
    output fwd1_sel, fwd2_sel, stall
  );
endinterface

// File: rtl/fwd_hazard_unit_inst_regs_decode.sv
// Combinational register-usage decode of one RV32 instruction.
module inst_regs_decode
  import fwd_hazard_unit_pkg::*;
(
  input  logic [31:0] i_inst,
  output logic        o_has_rd,
  output logic        o_has_rs1,
  output logic        o_has_rs2,
  output logic        o_is_load,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);
  logic [6:0] w_opcode;
  logic       w_unused;

  assign w_opcode = i_inst[6:0];
  assign o_rd     = i_inst[11:7];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign w_unused = ^{i_inst[31:25], i_inst[13:12]};

  always_comb begin
    o_has_rd  = !((w_opcode == OPC_BRANCH) || (w_opcode == OPC_STORE));
    // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field.
    o_has_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) ||
                  (w_opcode == OPC_JAL) ||
                  ((w_opcode == OPC_CSR) && i_inst[14]));
    o_has_rs2 = (w_opcode == OPC_ARI_RTYPE) || (w_opcode == OPC_BRANCH) ||
                (w_opcode == OPC_STORE);
    o_is_load = (w_opcode == OPC_LOAD);
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator over DEPTH downstream stages.
// Build option: define DATA_FWD_EN for forwarding; otherwise every hazard stalls.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2
) (
  input logic                clk,
  input logic                rst_n,
  fwd_hazard_unit_if.slave   hz
);
  localparam int SELW = $clog2(DEPTH + 1);

  sb_entry_t       r_sb [1:DEPTH];
  sb_entry_t       w_new;
  logic            w_has_rd, w_has_rs1, w_has_rs2, w_is_load;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [SELW-1:0] w_k1, w_k2, w_f1, w_f2;
  logic            w_ld1, w_ld2, w_hz1, w_hz2, w_stall;

  inst_regs_decode u_dec (
    .i_inst    (hz.id_inst),
    .o_has_rd  (w_has_rd),
    .o_has_rs1 (w_has_rs1),
    .o_has_rs2 (w_has_rs2),
    .o_is_load (w_is_load),
    .o_rd      (w_rd),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2)
  );

  // Scan oldest to youngest so the smallest matching stage is left standing.
  always_comb begin
    w_k1  = '0;
    w_ld1 = 1'b0;
    w_k2  = '0;
    w_ld2 = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (w_has_rs1 && r_sb[k].valid && (r_sb[k].rd == w_rs1)) begin
        w_k1  = SELW'(k);
        w_ld1 = r_sb[k].is_load;
      end
      if (w_has_rs2 && r_sb[k].valid && (r_sb[k].rd == w_rs2)) begin
        w_k2  = SELW'(k);
        w_ld2 = r_sb[k].is_load;
      end
    end
  end

`ifdef DATA_FWD_EN
  assign w_hz1 = w_ld1 && (w_k1 != SELW'(FWD_RF)) && (w_k1 < SELW'(LOAD_STAGE));
  assign w_hz2 = w_ld2 && (w_k2 != SELW'(FWD_RF)) && (w_k2 < SELW'(LOAD_STAGE));
  assign w_f1  = w_hz1 ? SELW'(FWD_RF) : w_k1;
  assign w_f2  = w_hz2 ? SELW'(FWD_RF) : w_k2;
`else
  logic w_unused_ld;
  // Without forwarding the load flag and load stage have no effect.
  assign w_unused_ld = w_ld1 ^ w_ld2 ^ (LOAD_STAGE > DEPTH);
  assign w_hz1 = (w_k1 != SELW'(FWD_RF));
  assign w_hz2 = (w_k2 != SELW'(FWD_RF));
  assign w_f1  = SELW'(FWD_RF);
  assign w_f2  = SELW'(FWD_RF);
`endif

  assign w_stall     = hz.id_valid && (w_hz1 || w_hz2);
  assign hz.stall    = w_stall;
  assign hz.fwd1_sel = hz.id_valid ? w_f1 : SELW'(FWD_RF);
  assign hz.fwd2_sel = hz.id_valid ? w_f2 : SELW'(FWD_RF);

  // x0 writers are recorded invalid so they can never be matched.
  assign w_new = '{valid:   hz.id_valid && w_has_rd && (w_rd != 5'd0),
                   rd:      w_rd,
                   is_load: w_is_load};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) r_sb[k] <= '0;
    end else if (hz.flush) begin
      for (int k = 1; k <= DEPTH; k++) r_sb[k] <= '0;
    end else if (hz.adv) begin
      r_sb[1] <= w_stall ? '0 : w_new;
      for (int k = DEPTH; k >= 2; k--) r_sb[k] <= r_sb[k-1];
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit (DEPTH=2, LOAD_STAGE=2); expectations follow DATA_FWD_EN.
module tb_fwd_hazard_unit;
  localparam int DEPTH = 2;
  localparam int LOAD_STAGE = 2;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        valid;
    logic        adv;
    logic        flush;
    logic [1:0]  e_sel1;
    logic [1:0]  e_sel2;
    logic        e_stall;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  fwd_hazard_unit_if #(.DEPTH(DEPTH)) hz ();

  fwd_hazard_unit #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction encoders
  function automatic logic [31:0] r_op(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic add_vec(input string name, input logic [31:0] inst, input logic valid,
                         input logic adv, input logic [1:0] s1, input logic [1:0] s2,
                         input logic st);
    vec_t v;
    v.name = name; v.inst = inst; v.valid = valid; v.adv = adv; v.flush = 1'b0;
    v.e_sel1 = s1; v.e_sel2 = s2; v.e_stall = st;
    vecs.push_back(v);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns later
  task automatic drive(input logic [31:0] inst, input logic valid, input logic adv, input logic flush);
    @(negedge clk);
    hz.id_inst = inst; hz.id_valid = valid; hz.adv = adv; hz.flush = flush;
    #1;
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] s1, input logic [1:0] s2, input logic st);
    chk({name, ".sel1"}, 32'(hz.fwd1_sel), 32'(s1));
    chk({name, ".sel2"}, 32'(hz.fwd2_sel), 32'(s2));
    chk({name, ".stall"}, 32'(hz.stall), 32'(st));
  endtask

  logic [31:0] jal_x1;
  int          n_stall;

  initial begin
    // jal x1 whose rs1 bit-field holds x2 (must be ignored)
    jal_x1 = {12'h000, 5'd2, 3'b000, 5'd1, 7'b1101111};
`ifdef DATA_FWD_EN
    add_vec("idle",      NOP,                   1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c1_prod",   r_op(F7_ADD, 5, 1, 2), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c1_cons",   r_op(F7_ADD, 6, 5, 5), 1'b1, 1'b1, 2'd1, 2'd1, 1'b0);
    add_vec("c2_prod",   r_op(F7_ADD, 5, 1, 2), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c2_nop",    NOP,                   1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c2_cons",   r_op(F7_SUB, 7, 0, 5), 1'b1, 1'b1, 2'd0, 2'd2, 1'b0);
    add_vec("c4_x0w",    r_op(F7_ADD, 0, 1, 2), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_x0r",    r_op(F7_ADD, 3, 0, 0), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_sw",     sw(5, 1),              1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_use",    r_op(F7_ADD, 6, 5, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("invalid",   r_op(F7_ADD, 1, 6, 6), 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("hold",      r_op(F7_ADD, 2, 6, 0), 1'b1, 1'b0, 2'd2, 2'd0, 1'b0);
    add_vec("hold_adv",  r_op(F7_ADD, 2, 6, 0), 1'b1, 1'b1, 2'd2, 2'd0, 1'b0);
    add_vec("jal",       jal_x1,                1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("itype",     addi(4, 2, 1),         1'b1, 1'b1, 2'd2, 2'd0, 1'b0);
    add_vec("two_stage", r_op(F7_ADD, 9, 4, 1), 1'b1, 1'b1, 2'd1, 2'd2, 1'b0);
    add_vec("dup_rd",    r_op(F7_ADD, 9, 1, 1), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("youngest",  r_op(F7_ADD, 10, 9, 9), 1'b1, 1'b1, 2'd1, 2'd1, 1'b0);
`else
    add_vec("idle",      NOP,                   1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c1_prod",   r_op(F7_ADD, 5, 1, 2), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c1_st1",    r_op(F7_ADD, 6, 5, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("c1_st2",    r_op(F7_ADD, 6, 5, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("c1_go",     r_op(F7_ADD, 6, 5, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c2_prod",   r_op(F7_ADD, 5, 1, 2), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c2_nop",    NOP,                   1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c2_st",     r_op(F7_SUB, 7, 0, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("c2_go",     r_op(F7_SUB, 7, 0, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_x0w",    r_op(F7_ADD, 0, 1, 2), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_x0r",    r_op(F7_ADD, 3, 0, 0), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_sw",     sw(5, 1),              1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("c4_use",    r_op(F7_ADD, 6, 5, 5), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("invalid",   r_op(F7_ADD, 1, 6, 6), 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("hold",      r_op(F7_ADD, 2, 6, 0), 1'b1, 1'b0, 2'd0, 2'd0, 1'b1);
    add_vec("hold_adv",  r_op(F7_ADD, 2, 6, 0), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("hold_go",   r_op(F7_ADD, 2, 6, 0), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("jal",       jal_x1,                1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("itype_st",  addi(4, 2, 1),         1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("itype_go",  addi(4, 2, 1),         1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("two_st1",   r_op(F7_ADD, 9, 4, 1), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("two_st2",   r_op(F7_ADD, 9, 4, 1), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
    add_vec("two_go",    r_op(F7_ADD, 9, 4, 1), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("dup_rd",    r_op(F7_ADD, 9, 1, 1), 1'b1, 1'b1, 2'd0, 2'd0, 1'b0);
    add_vec("youngest",  r_op(F7_ADD, 10, 9, 9), 1'b1, 1'b1, 2'd0, 2'd0, 1'b1);
`endif

    rst_n = 1'b0;
    hz.id_inst = '0; hz.id_valid = 1'b0; hz.adv = 1'b0; hz.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven cases
    foreach (vecs[i]) begin
      drive(vecs[i].inst, vecs[i].valid, vecs[i].adv, vecs[i].flush);
      chk_out(vecs[i].name, vecs[i].e_sel1, vecs[i].e_sel2, vecs[i].e_stall);
    end

    // load-use: stall extends while adv=0, then LOAD_STAGE-1 stall cycles
`ifdef DATA_FWD_EN
    n_stall = 1;
`else
    n_stall = 2;
`endif
    drive(NOP, 1'b0, 1'b0, 1'b1);
    chk_out("lu_flush", 2'd0, 2'd0, 1'b0);
    drive(lw(5, 1), 1'b1, 1'b1, 1'b0);
    chk_out("lu_load", 2'd0, 2'd0, 1'b0);
    drive(r_op(F7_ADD, 6, 5, 3), 1'b1, 1'b0, 1'b0);
    chk_out("lu_noadv", 2'd0, 2'd0, 1'b1);
    for (int i = 0; i < n_stall; i++) begin
      drive(r_op(F7_ADD, 6, 5, 3), 1'b1, 1'b1, 1'b0);
      chk_out("lu_stall", 2'd0, 2'd0, 1'b1);
    end
    drive(r_op(F7_ADD, 6, 5, 3), 1'b1, 1'b1, 1'b0);
`ifdef DATA_FWD_EN
    chk_out("lu_fwd", 2'd2, 2'd0, 1'b0);
`else
    chk_out("lu_fwd", 2'd0, 2'd0, 1'b0);
`endif

    // flush beats adv
    drive(lw(5, 1), 1'b1, 1'b1, 1'b0);
    chk_out("fl_load", 2'd0, 2'd0, 1'b0);
    drive(r_op(F7_ADD, 6, 5, 3), 1'b1, 1'b1, 1'b1);
    chk_out("fl_same", 2'd0, 2'd0, 1'b1);
    drive(r_op(F7_ADD, 6, 5, 3), 1'b1, 1'b1, 1'b0);
    chk_out("fl_after", 2'd0, 2'd0, 1'b0);

    // async reset in the middle of a load-use stall
    drive(lw(5, 1), 1'b1, 1'b1, 1'b0);
    chk_out("rs_load", 2'd0, 2'd0, 1'b0);
    drive(r_op(F7_ADD, 7, 5, 3), 1'b1, 1'b1, 1'b0);
    chk_out("rs_stall", 2'd0, 2'd0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_out("rs_async", 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(r_op(F7_ADD, 7, 5, 3), 1'b1, 1'b1, 1'b0);
    chk_out("rs_release", 2'd0, 2'd0, 1'b0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard controller for the RV32 pipeline; generalises the single-stage rs2-only forwarding select to rs1 and rs2 across DEPTH downstream stages. It keeps an internal in-flight scoreboard of destination registers and produces per-operand forwarding selects plus a stall/bubble request for the decode stage. It sits beside the decode stage and drives the operand muxes that feed the execute stage.

## Interface
- DEPTH, 2, number of downstream stages tracked (stage 1 = execute … stage DEPTH = writeback); legal 1..7
- LOAD_STAGE, 2, first stage at which load data can be forwarded; legal 1..DEPTH
- SELW, $clog2(DEPTH+1), width of the forwarding selects (derived, not overridden)
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_inst  in  32  instruction currently in decode
- id_valid  in  1  id_inst is a real instruction, not a bubble
- adv  in  1  pipeline advances this cycle
- flush  in  1  kill all in-flight entries (branch mispredict/jump)
- fwd1_sel  out  SELW  rs1 source: 0 = register file, k = stage k result
- fwd2_sel  out  SELW  rs2 source, same encoding
- stall  out  1  hold decode/fetch and inject a bubble into stage 1

## Operation
- Decode: has_rd = false for OPC_BRANCH and OPC_STORE, true otherwise; rd = inst[11:7]. has_rs1 = false for LUI, AUIPC, JAL, and CSR with funct3[2]=1; has_rs2 = true only for OPC_ARI_RTYPE, OPC_BRANCH, OPC_STORE. is_load = (opcode == OPC_LOAD).
- Scoreboard: DEPTH entries {valid, rd, is_load}; an entry with rd = 0 is stored with valid = 0 (x0 never matches).
- Match: operand rsN of id_inst matches entry k if has_rsN, entry valid, and entry.rd == rsN. With several matches, the smallest k (youngest) wins.
- Load-use: winning match with is_load and k < LOAD_STAGE → stall = 1; that operand's select = 0.
- Otherwise fwdN_sel = k of the winning match, or 0 with no match.
- stall is asserted only when id_valid = 1; with id_valid = 0 all outputs are 0.
- Update priority: flush > adv > hold.
  - flush: all entries valid = 0.
  - adv with stall = 0: entry[1] ← decoded id_inst (valid = id_valid && has_rd), entry[k] ← entry[k-1].
  - adv with stall = 1: entry[1] ← bubble, rest shift.
  - no adv: hold.
- Entry DEPTH shifts out; the register file is assumed written by then, so no match remains.

## Timing
- fwd1_sel, fwd2_sel and stall are combinational from id_inst, id_valid and registered scoreboard state; 0-cycle latency, no input-to-output flop.
- Scoreboard changes only at posedge clk; results are visible the same cycle the next instruction sits in decode.
- Load-use stall lasts exactly LOAD_STAGE − k cycles with adv held high; it extends while adv = 0.
- Reset (async assert, any cycle, including mid-stall): all entries invalid; outputs 0 immediately; release is synchronous to clk.
- flush with adv in the same cycle: flush wins; next cycle all outputs 0.

## Configuration
- DATA_FWD_EN defined: forwarding as above.
- Not defined: fwdN_sel tied to 0; any match at any stage (load or not) asserts stall, so instructions wait until the writer leaves stage DEPTH.

## Structure
- Opcode constants come from Opcode.vh.
- Shared package/header holds the scoreboard entry layout (valid, rd[4:0], is_load) and the select encoding constants FWD_RF = 0.
- One sub-module, inst_regs_decode: a combinational extraction of has_rd, has_rs1, has_rs2, is_load, rd, rs1 and rs2. It is instantiated once, for id_inst.
- The top level holds the shift register, match/priority logic and the stall generation.

## Test plan
All cases use DEPTH = 2, LOAD_STAGE = 2, adv = 1 unless stated.
1. add x5,x1,x2 then add x6,x5,x5 → second instruction fwd1_sel = fwd2_sel = 1, stall = 0.
2. add x5,…; nop; sub x7,x0,x5 → fwd2_sel = 2, fwd1_sel = 0 (rs1 = x0).
3. lw x5,0(x1) then add x6,x5,x3 → stall = 1 for one cycle, then fwd1_sel = 2, stall = 0.
4. add x0,x1,x2 then add x3,x0,x0, and sw x5,0(x1) then add x6,x5,x5 → all selects 0.
5. lw x5 at stage 1 with flush = 1 → the next cycle stall = 0, selects 0; rst_n low mid-stall → stall drops without a clock edge.
6. DATA_FWD_EN undefined, case 1 → stall = 1 for 2 cycles, selects always 0.
